// File: rtl/frame_gen_pkg.sv
// rtl/frame_gen_pkg.sv - shared constants for the frame pattern generator
package frame_gen_pkg;

  typedef enum logic [3:0] {
    MODE_BLACK   = 4'd0,
    MODE_WHITE   = 4'd1,
    MODE_HRAMP   = 4'd2,
    MODE_VRAMP   = 4'd3,
    MODE_CHECKER = 4'd4,
    MODE_BARS    = 4'd5,
    MODE_BOX     = 4'd6,
    MODE_PRBS    = 4'd7
  } mode_e;

  // Index 0 is the leftmost bar; bit 0 = R, bit 1 = G, bit 2 = B
  localparam logic [7:0][2:0] BAR_CODES = {3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd7};

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/pattern_ramp_acc.sv
// rtl/pattern_ramp_acc.sv - exact floor(n*MAXV/(SPAN-1)) ramp built from a quotient/remainder accumulator
module pattern_ramp_acc #(
  parameter int SPAN  = 640,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             step,
  output logic [PIX_W-1:0] value
);
  localparam int MAXV = (1 << PIX_W) - 1;
  localparam int DEN  = SPAN - 1;
  localparam int Q    = MAXV / DEN;
  localparam int R    = MAXV % DEN;
  localparam int RW   = $clog2(SPAN) + 1;

  logic [PIX_W-1:0] val_q, val_d, val_b;
  logic [RW-1:0]    rem_q, rem_d, rem_b, rem_s;

  // Clear applies first so a clear+step pair yields the value for n=1
  always_comb begin
    val_b = clr ? '0 : val_q;
    rem_b = clr ? '0 : rem_q;
    rem_s = rem_b + RW'(R);
    val_d = val_b;
    rem_d = rem_b;
    if (step) begin
      if (rem_s >= RW'(DEN)) begin
        val_d = val_b + PIX_W'(Q + 1);
        rem_d = rem_s - RW'(DEN);
      end else begin
        val_d = val_b + PIX_W'(Q);
        rem_d = rem_s;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      rem_q <= '0;
    end else begin
      val_q <= val_d;
      rem_q <= rem_d;
    end
  end

  assign value = val_q;

endmodule

// File: rtl/frame_pattern_gen_mc.sv
// rtl/frame_pattern_gen_mc.sv - multi-channel frame-locked test-pattern generator
module frame_pattern_gen_mc
  import frame_gen_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int PIX_W    = 8,
  parameter int CHANNELS = 3,
  parameter int TILE_W   = 80,
  parameter int TILE_H   = 60,
  parameter int BOX_SIZE = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                sel,
  input  logic                      fval_posedge,
  input  logic                      lval_negedge,
  input  logic                      dval,
  output logic [CHANNELS*PIX_W-1:0] pix_out,
  output logic                      pix_valid,
  output logic [15:0]               frame_cnt,
  output logic                      timing_err
);
  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = $clog2(V_ACTIVE);
  localparam int TXW   = $clog2(TILE_W + 1);
  localparam int TYW   = $clog2(TILE_H + 1);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = $clog2(BAR_W + 1);
  localparam logic [PIX_W-1:0] MAXV = '1;

  logic [3:0]                mode_q, mode_d, mode_b;
  logic [XW-1:0]             x_q, x_d, x_b, box_q, box_d, box_b;
  logic [YW-1:0]             y_q, y_d, y_b;
  logic                      x_sat_q, x_sat_d, x_sat_b, y_sat_q, y_sat_d, y_sat_b;
  logic                      err_q, err_d;
  logic [15:0]               fcnt_q, fcnt_d, lfsr_q, lfsr_d, lfsr_b;
  logic [TXW-1:0]            tx_q, tx_d, tx_b;
  logic [TYW-1:0]            ty_q, ty_d, ty_b;
  logic                      px_q, px_d, px_b, py_q, py_d, py_b;
  logic [BW-1:0]             bpos_q, bpos_d, bpos_b;
  logic [2:0]                bidx_q, bidx_d, bidx_b, code;
  logic [CHANNELS*PIX_W-1:0] pix_q, pix_d;
  logic                      valid_q;
  logic [PIX_W-1:0]          h_val, v_val, h_b, v_b, chan_v;
  logic                      lval, x_adv, h_clr, h_step, v_step, in_box;

  // "_b" is the state the current beat renders from: a frame start substitutes the fresh frame
  assign mode_b  = fval_posedge ? sel : mode_q;
  assign x_b     = fval_posedge ? '0 : x_q;
  assign x_sat_b = x_sat_q & ~fval_posedge;
  assign y_b     = fval_posedge ? '0 : y_q;
  assign y_sat_b = y_sat_q & ~fval_posedge;
  assign lfsr_b  = fval_posedge ? LFSR_SEED : lfsr_q;
  assign box_b   = !fval_posedge ? box_q :
                   (box_q == XW'(H_ACTIVE - BOX_SIZE)) ? '0 : box_q + XW'(1);
  assign tx_b    = fval_posedge ? '0 : tx_q;
  assign px_b    = px_q & ~fval_posedge;
  assign ty_b    = fval_posedge ? '0 : ty_q;
  assign py_b    = py_q & ~fval_posedge;
  assign bpos_b  = fval_posedge ? '0 : bpos_q;
  assign bidx_b  = fval_posedge ? '0 : bidx_q;
  assign h_b     = fval_posedge ? '0 : h_val;
  assign v_b     = fval_posedge ? '0 : v_val;

  assign lval   = lval_negedge & ~fval_posedge;
  assign x_adv  = dval & (x_b != XW'(H_ACTIVE - 1));
  assign h_clr  = fval_posedge | lval_negedge;
  assign h_step = x_adv & ~lval;
  assign v_step = lval & (y_q != YW'(V_ACTIVE - 1));
  assign code   = BAR_CODES[bidx_b];
  assign in_box = (x_b >= box_b) && ({1'b0, x_b} < {1'b0, box_b} + (XW+1)'(BOX_SIZE)) &&
                  (y_b < YW'(BOX_SIZE));

  pattern_ramp_acc #(.SPAN(H_ACTIVE), .PIX_W(PIX_W)) u_h_ramp (
    .clk(clk), .rst(rst), .clr(h_clr), .step(h_step), .value(h_val)
  );

  pattern_ramp_acc #(.SPAN(V_ACTIVE), .PIX_W(PIX_W)) u_v_ramp (
    .clk(clk), .rst(rst), .clr(fval_posedge), .step(v_step), .value(v_val)
  );

  always_comb begin
    mode_d  = mode_b;
    x_d     = x_b;
    x_sat_d = x_sat_b;
    y_d     = y_b;
    y_sat_d = y_sat_b;
    err_d   = err_q & ~fval_posedge;
    fcnt_d  = fcnt_q + (fval_posedge ? 16'd1 : 16'd0);
    lfsr_d  = dval ? lfsr_step(lfsr_b) : lfsr_b;
    box_d   = box_b;
    tx_d    = tx_b;
    px_d    = px_b;
    ty_d    = ty_b;
    py_d    = py_b;
    bpos_d  = bpos_b;
    bidx_d  = bidx_b;
    pix_d   = '0;
    chan_v  = '0;

    if (x_adv) begin
      x_d = x_b + XW'(1);
      if (tx_b == TXW'(TILE_W - 1)) begin
        tx_d = '0;
        px_d = ~px_b;
      end else begin
        tx_d = tx_b + TXW'(1);
      end
      if (bidx_b != 3'd7) begin
        if (bpos_b == BW'(BAR_W - 1)) begin
          bpos_d = '0;
          bidx_d = bidx_b + 3'd1;
        end else begin
          bpos_d = bpos_b + BW'(1);
        end
      end
    end else if (dval) begin
      // First beat at the last column is legal; any further beat is an overrun
      if (x_sat_b) err_d = 1'b1;
      else         x_sat_d = 1'b1;
    end

    if (lval) begin
      x_d     = '0;
      x_sat_d = 1'b0;
      tx_d    = '0;
      px_d    = 1'b0;
      bpos_d  = '0;
      bidx_d  = '0;
      if (v_step) begin
        y_d = y_q + YW'(1);
        if (ty_q == TYW'(TILE_H - 1)) begin
          ty_d = '0;
          py_d = ~py_q;
        end else begin
          ty_d = ty_q + TYW'(1);
        end
      end else if (y_sat_q) begin
        err_d = 1'b1;
      end else begin
        y_sat_d = 1'b1;
      end
    end

    for (int c = 0; c < CHANNELS; c++) begin
      case (mode_b)
        MODE_WHITE:   chan_v = MAXV;
        MODE_HRAMP:   chan_v = h_b;
        MODE_VRAMP:   chan_v = v_b;
        MODE_CHECKER: chan_v = (px_b ^ py_b) ? MAXV : '0;
        MODE_BARS:    chan_v = code[2'(c % 3)] ? MAXV : '0;
        MODE_BOX:     chan_v = in_box ? MAXV : '0;
        MODE_PRBS:    chan_v = lfsr_b[PIX_W-1:0];
        default:      chan_v = '0;
      endcase
      pix_d[c*PIX_W +: PIX_W] = dval ? chan_v : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= '0;
      x_q     <= '0;
      x_sat_q <= 1'b0;
      y_q     <= '0;
      y_sat_q <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      box_q   <= '0;
      tx_q    <= '0;
      px_q    <= 1'b0;
      ty_q    <= '0;
      py_q    <= 1'b0;
      bpos_q  <= '0;
      bidx_q  <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      x_q     <= x_d;
      x_sat_q <= x_sat_d;
      y_q     <= y_d;
      y_sat_q <= y_sat_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
      lfsr_q  <= lfsr_d;
      box_q   <= box_d;
      tx_q    <= tx_d;
      px_q    <= px_d;
      ty_q    <= ty_d;
      py_q    <= py_d;
      bpos_q  <= bpos_d;
      bidx_q  <= bidx_d;
      pix_q   <= pix_d;
      valid_q <= dval;
    end
  end

  assign pix_out    = pix_q;
  assign pix_valid  = valid_q;
  assign frame_cnt  = fcnt_q;
  assign timing_err = err_q;

endmodule

// File: tb/tb_frame_pattern_gen_mc.sv
// tb/tb_frame_pattern_gen_mc.sv - directed and randomized checks of frame_pattern_gen_mc against a pixel-rule model
module tb_frame_pattern_gen_mc;
  localparam int H = 640, V = 480, PW = 8, CH = 3, TW = 80, TH = 60, BOX = 32;
  localparam int MAXV = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sel;
  logic        fval_posedge, lval_negedge, dval;
  logic [23:0] pix_out;
  logic        pix_valid;
  logic [15:0] frame_cnt;
  logic        timing_err;

  always #5 clk = ~clk;

  frame_pattern_gen_mc #(
    .H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW), .CHANNELS(CH),
    .TILE_W(TW), .TILE_H(TH), .BOX_SIZE(BOX)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .fval_posedge(fval_posedge),
    .lval_negedge(lval_negedge), .dval(dval), .pix_out(pix_out),
    .pix_valid(pix_valid), .frame_cnt(frame_cnt), .timing_err(timing_err)
  );

  int          checks = 0;
  int          errors = 0;
  int          m_mode, m_beats, m_lines, m_box;
  logic        m_err, exp_valid;
  logic [15:0] m_fc, m_lfsr, fc0;
  logic [23:0] exp_pix, obs;
  logic [23:0] cap [1024];
  int          bar_code [8] = '{7, 3, 6, 2, 5, 1, 4, 0};

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [23:0] ref_pix(input int mode, input int x, input int y);
    logic [23:0] p = '0;
    int v, b;
    for (int c = 0; c < CH; c++) begin
      case (mode)
        1: v = MAXV;
        2: v = x * MAXV / (H - 1);
        3: v = y * MAXV / (V - 1);
        4: v = (((x / TW) + (y / TH)) % 2 == 1) ? MAXV : 0;
        5: begin
          b = x / (H / 8);
          if (b > 7) b = 7;
          v = (((bar_code[b] >> (c % 3)) & 1) == 1) ? MAXV : 0;
        end
        6: v = (x >= m_box && x < m_box + BOX && y < BOX) ? MAXV : 0;
        7: v = int'(m_lfsr[PW-1:0]);
        default: v = 0;
      endcase
      p[c*PW +: PW] = v[PW-1:0];
    end
    return p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_beats = 0; m_lines = 0; m_box = 0;
    m_err = 1'b0; m_fc = '0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_step(input bit f, input bit l, input bit d);
    if (f) begin
      m_mode = int'(sel); m_beats = 0; m_lines = 0; m_err = 1'b0;
      m_fc++; m_lfsr = 16'hACE1;
      m_box = (m_box == H - BOX) ? 0 : m_box + 1;
    end
    exp_valid = d;
    exp_pix = d ? ref_pix(m_mode, (m_beats < H) ? m_beats : H - 1,
                          (m_lines < V) ? m_lines : V - 1) : '0;
    if (d) begin
      m_lfsr = ref_lfsr(m_lfsr);
      m_beats++;
      if (m_beats > H) m_err = 1'b1;
    end
    if (l && !f) begin
      m_beats = 0;
      m_lines++;
      if (m_lines > V) m_err = 1'b1;
    end
  endtask

  task automatic cyc(input bit f, input bit l, input bit d);
    fval_posedge = f; lval_negedge = l; dval = d;
    model_step(f, l, d);
    @(posedge clk);
    #1;
    obs = pix_out;
    chk("pix_valid", 64'(pix_valid), 64'(exp_valid));
    chk("pix_out", 64'(pix_out), 64'(exp_pix));
    chk("timing_err", 64'(timing_err), 64'(m_err));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_fc));
    fval_posedge = 1'b0; lval_negedge = 1'b0; dval = 1'b0;
  endtask

  task automatic start(input logic [3:0] s, input bit d);
    sel = s;
    cyc(1'b1, 1'b0, d);
  endtask

  task automatic skip(input int n);
    repeat (n) cyc(1'b0, 1'b1, 1'b0);
  endtask

  // Sends a line of beats with random idle gaps; merge puts lval on the last beat
  task automatic run_line(input int beats, input int gap_pct, input bit merge);
    int n = 0;
    bit last = 1'b0;
    while (n < beats) begin
      if (gap_pct != 0 && int'($urandom_range(99)) < gap_pct) begin
        cyc(1'b0, 1'b0, 1'b0);
      end else begin
        last = merge && (n == beats - 1);
        cyc(1'b0, last, 1'b1);
        cap[n] = obs;
        n++;
      end
    end
    if (!last) cyc(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = '0;
    fval_posedge = 1'b0; lval_negedge = 1'b0; dval = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset pix_out", 64'(pix_out), 64'h0);
    chk("reset pix_valid", 64'(pix_valid), 64'h0);
    chk("reset frame_cnt", 64'(frame_cnt), 64'h0);
    chk("reset timing_err", 64'(timing_err), 64'h0);
    rst = 1'b0;

    // Ramps
    start(4'd2, 1'b0);
    run_line(640, 30, 1'b0);
    chk("hramp x0", 64'(cap[0]), 64'h0);
    chk("hramp x1", 64'(cap[1]), 64'h0);
    chk("hramp x3", 64'(cap[3]), 64'h010101);
    chk("hramp x639", 64'(cap[639]), 64'hFFFFFF);
    start(4'd3, 1'b0);
    run_line(2, 0, 1'b0);
    chk("vramp y0", 64'(cap[0]), 64'h0);
    skip(478);
    run_line(1, 0, 1'b0);
    chk("vramp y479", 64'(cap[0]), 64'hFFFFFF);

    // Checker and bars
    start(4'd4, 1'b0);
    run_line(81, 20, 1'b0);
    chk("checker 0,0", 64'(cap[0]), 64'h0);
    chk("checker 80,0", 64'(cap[80]), 64'hFFFFFF);
    skip(59);
    run_line(81, 0, 1'b0);
    chk("checker 0,60", 64'(cap[0]), 64'hFFFFFF);
    chk("checker 80,60", 64'(cap[80]), 64'h0);
    start(4'd5, 1'b0);
    run_line(640, 10, 1'b0);
    chk("bars x0", 64'(cap[0]), 64'hFFFFFF);
    chk("bars x80", 64'(cap[80]), 64'h00FFFF);
    chk("bars x639", 64'(cap[639]), 64'h0);

    // Mid-frame sel change is ignored until the next frame
    start(4'd1, 1'b0);
    fc0 = m_fc;
    repeat (300) cyc(1'b0, 1'b0, 1'b1);
    sel = 4'd0;
    run_line(200, 10, 1'b0);
    chk("sel ignored mid-frame", 64'(cap[199]), 64'hFFFFFF);
    start(4'd0, 1'b0);
    chk("frame_cnt step", 64'(frame_cnt), 64'(16'(fc0 + 16'd1)));
    run_line(4, 0, 1'b0);
    chk("black next frame", 64'(cap[0]), 64'h0);

    // Asynchronous reset in the middle of a line
    repeat (10) cyc(1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async rst pix_valid", 64'(pix_valid), 64'h0);
    chk("async rst pix_out", 64'(pix_out), 64'h0);
    chk("async rst frame_cnt", 64'(frame_cnt), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Moving box, first frames after reset
    start(4'd6, 1'b0);
    run_line(64, 0, 1'b0);
    chk("box f1 x0", 64'(cap[0]), 64'h0);
    chk("box f1 x1", 64'(cap[1]), 64'hFFFFFF);
    chk("box f1 x32", 64'(cap[32]), 64'hFFFFFF);
    chk("box f1 x33", 64'(cap[33]), 64'h0);
    skip(30);
    run_line(40, 0, 1'b0);
    chk("box f1 y31", 64'(cap[32]), 64'hFFFFFF);
    run_line(40, 0, 1'b0);
    chk("box f1 y32", 64'(cap[1]), 64'h0);
    start(4'd6, 1'b0);
    run_line(40, 0, 1'b0);
    chk("box f2 x1", 64'(cap[1]), 64'h0);
    chk("box f2 x33", 64'(cap[33]), 64'hFFFFFF);
    start(4'd6, 1'b0);
    run_line(40, 0, 1'b0);
    chk("box f3 x34", 64'(cap[34]), 64'hFFFFFF);
    chk("box f3 x35", 64'(cap[35]), 64'h0);
    for (int i = 0; i < 700 && m_box != H - BOX; i++) start(4'd6, 1'b0);
    run_line(640, 0, 1'b0);
    chk("box 608 x607", 64'(cap[607]), 64'h0);
    chk("box 608 x608", 64'(cap[608]), 64'hFFFFFF);
    chk("box 608 x639", 64'(cap[639]), 64'hFFFFFF);
    start(4'd6, 1'b0);
    run_line(40, 0, 1'b0);
    chk("box wrap x0", 64'(cap[0]), 64'hFFFFFF);
    chk("box wrap x32", 64'(cap[32]), 64'h0);

    // Line overrun, frame start clearing it, fval winning over lval
    start(4'd2, 1'b0);
    run_line(641, 5, 1'b0);
    chk("overrun err", 64'(timing_err), 64'h1);
    chk("overrun px640", 64'(cap[639]), 64'hFFFFFF);
    chk("overrun px641", 64'(cap[640]), 64'hFFFFFF);
    sel = 4'd6;
    cyc(1'b1, 1'b1, 1'b0);
    chk("err cleared", 64'(timing_err), 64'h0);
    skip(31);
    run_line(3, 0, 1'b0);
    chk("fval over lval y", 64'(cap[2]), 64'hFFFFFF);
    skip(480);
    chk("line overrun err", 64'(timing_err), 64'h1);

    // PRBS with dval coincident with frame start
    start(4'd7, 1'b1);
    chk("prbs first", 64'(obs), 64'hE1E1E1);
    run_line(200, 30, 1'b1);

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      start(4'($urandom_range(15)), 1'($urandom_range(1)));
      for (int l = 0; l < 3; l++) begin
        run_line(int'($urandom_range(1, 640)), 25, 1'($urandom_range(1)));
        skip(int'($urandom_range(0, 100)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
